// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller and its helpers.
package hazard_pkg;

    localparam int REG_AW_DEF = 5;
    localparam int XLEN_DEF   = 32;
    localparam int CNT_W_DEF  = 32;

    // Sequencing states, exposed on state_o for debug.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FREEZE = 2'd1,
        ST_LU     = 2'd2
    } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: a load in EX writes a register the ID instruction reads.
// Writes to x0 never create a dependency.
module hazard_detect
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic              use_rs1,
    input  logic              use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_memread,
    output logic              lu_hz
);

    // Pure compare, no state.
    always_comb begin
        lu_hz = ex_memread && (ex_rd != '0) &&
                ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core.
// Priority: memory stall > branch redirect (live or replayed) > load-use bubble.
// A redirect seen while frozen is parked in pend/pend_tgt and fires on release;
// a newer redirect overwrites an older parked one.
// Handshake: none; br_redirect_i is a single-cycle pulse qualified by itself,
// and br_target_i is only meaningful in that cycle.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int XLEN   = XLEN_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_memread_i,
    input  logic              br_redirect_i,
    input  logic [XLEN-1:0]   br_target_i,
    input  logic              icache_stall_i,
    input  logic              dcache_stall_i,
    output logic              pc_write_o,
    output logic              pc_redirect_o,
    output logic [XLEN-1:0]   pc_target_o,
    output logic              if_id_stall_o,
    output logic              if_id_flush_o,
    output logic              id_ex_bubble_o,
    output logic              back_stall_o,
    output logic [1:0]        state_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    state_t            state;
    state_t            state_nxt;
    logic              pend;
    logic [XLEN-1:0]   pend_tgt;
    logic              pend_set;
    logic              pend_clr;
    logic              flush_inc;
    logic              mem_stall;
    logic              lu_hz;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    assign mem_stall = icache_stall_i | dcache_stall_i;

    hazard_detect #(.REG_AW(REG_AW)) u_detect (
        .rs1        (id_rs1_i),
        .rs2        (id_rs2_i),
        .use_rs1    (id_use_rs1_i),
        .use_rs2    (id_use_rs2_i),
        .ex_rd      (ex_rd_i),
        .ex_memread (ex_memread_i),
        .lu_hz      (lu_hz)
    );

    // Next state and pipeline controls; outputs fall to their reset values while reset is held.
    always_comb begin
        state_nxt      = ST_RUN;
        pc_write_o     = 1'b1;
        pc_redirect_o  = 1'b0;
        pc_target_o    = '0;
        if_id_stall_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_bubble_o = 1'b0;
        back_stall_o   = 1'b0;
        pend_set       = 1'b0;
        pend_clr       = 1'b0;
        flush_inc      = 1'b0;
        if (!rst_i) begin
            state_nxt = ST_RUN;
        end else if (mem_stall) begin
            pc_write_o    = 1'b0;
            if_id_stall_o = 1'b1;
            back_stall_o  = 1'b1;
            pend_set      = br_redirect_i;
            state_nxt     = ST_FREEZE;
        end else if (br_redirect_i || pend) begin
            // The ID instruction is squashed, so any load-use hazard is moot.
            pc_redirect_o  = 1'b1;
            pc_target_o    = br_redirect_i ? br_target_i : pend_tgt;
            if_id_flush_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
            pend_clr       = 1'b1;
            flush_inc      = 1'b1;
        end else if (lu_hz && (state != ST_LU)) begin
            pc_write_o     = 1'b0;
            if_id_stall_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
            state_nxt      = ST_LU;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= ST_RUN;
        else        state <= state_nxt;
    end

    // Parked redirect: newest redirect during a freeze wins.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pend     <= 1'b0;
            pend_tgt <= '0;
        end else if (pend_set) begin
            pend     <= 1'b1;
            pend_tgt <= br_target_i;
        end else if (pend_clr) begin
            pend     <= 1'b0;
        end
    end

    // Performance counters, wrapping naturally.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_write_o) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc)   flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign state_o     = state;
    assign stall_cnt_o = stall_cnt;
    assign flush_cnt_o = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic against a
// behavioural model that tracks what the previous cycle did and any parked redirect.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int REG_AW = 5;
    localparam int XLEN   = 32;
    localparam int CNT_W  = 32;
    localparam int EW     = 40;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic [REG_AW-1:0] id_rs1_i, id_rs2_i, ex_rd_i;
    logic              id_use_rs1_i, id_use_rs2_i, ex_memread_i;
    logic              br_redirect_i, icache_stall_i, dcache_stall_i;
    logic [XLEN-1:0]   br_target_i;
    logic              pc_write_o, pc_redirect_o, if_id_stall_o, if_id_flush_o;
    logic              id_ex_bubble_o, back_stall_o;
    logic [XLEN-1:0]   pc_target_o;
    logic [1:0]        state_o;
    logic [CNT_W-1:0]  stall_cnt_o, flush_cnt_o;

    hazard_ctrl #(.REG_AW(REG_AW), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .id_rs1_i       (id_rs1_i),
        .id_rs2_i       (id_rs2_i),
        .id_use_rs1_i   (id_use_rs1_i),
        .id_use_rs2_i   (id_use_rs2_i),
        .ex_rd_i        (ex_rd_i),
        .ex_memread_i   (ex_memread_i),
        .br_redirect_i  (br_redirect_i),
        .br_target_i    (br_target_i),
        .icache_stall_i (icache_stall_i),
        .dcache_stall_i (dcache_stall_i),
        .pc_write_o     (pc_write_o),
        .pc_redirect_o  (pc_redirect_o),
        .pc_target_o    (pc_target_o),
        .if_id_stall_o  (if_id_stall_o),
        .if_id_flush_o  (if_id_flush_o),
        .id_ex_bubble_o (id_ex_bubble_o),
        .back_stall_o   (back_stall_o),
        .state_o        (state_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_prev: what the previous cycle did: 0 = advanced/redirected, 1 = frozen, 2 = load-use bubble.
    int            m_prev, n_prev;
    bit            m_pend, n_pend;
    logic [31:0]   m_tgt, n_tgt;
    logic [31:0]   m_stall, n_stall, m_flush, n_flush;

    task automatic model_reset();
        m_prev = 0; m_pend = 0; m_tgt = '0; m_stall = '0; m_flush = '0;
    endtask

    task automatic model_eval();
        bit mem, hz, pw, red, fl, st, bb, bk;
        logic [31:0] tg;
        logic [1:0]  stv;
        mem = icache_stall_i || dcache_stall_i;
        hz  = ex_memread_i && (ex_rd_i != 0) &&
              ((id_use_rs1_i && id_rs1_i == ex_rd_i) || (id_use_rs2_i && id_rs2_i == ex_rd_i));
        pw = 1; red = 0; tg = '0; fl = 0; st = 0; bb = 0; bk = 0;
        n_prev = 0; n_pend = m_pend; n_tgt = m_tgt; n_flush = m_flush;
        if (mem) begin
            pw = 0; st = 1; bk = 1; n_prev = 1;
            if (br_redirect_i) begin n_pend = 1; n_tgt = br_target_i; end
        end else if (br_redirect_i || m_pend) begin
            red = 1; fl = 1; bb = 1;
            tg = br_redirect_i ? br_target_i : m_tgt;
            n_pend = 0; n_flush = m_flush + 1;
        end else if (hz && m_prev != 2) begin
            pw = 0; st = 1; bb = 1; n_prev = 2;
        end
        n_stall = pw ? m_stall : m_stall + 1;
        stv = 2'(m_prev);
        exp_q.push_back({pw, red, tg, fl, st, bb, bk, stv});
    endtask

    // ---------------- driver ----------------
    task automatic drive(input bit ic, input bit dc, input bit br, input logic [31:0] tgt,
                         input bit mr, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input bit u1, input bit u2);
        icache_stall_i = ic; dcache_stall_i = dc; br_redirect_i = br; br_target_i = tgt;
        ex_memread_i = mr; ex_rd_i = rd; id_rs1_i = rs1; id_rs2_i = rs2;
        id_use_rs1_i = u1; id_use_rs2_i = u2;
    endtask

    task automatic idle();
        drive(0, 0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    endtask

    // Called 1 time unit after a rising edge with inputs already driven.
    task automatic step();
        logic [EW-1:0] e;
        #2;
        model_eval();
        e = exp_q.pop_front();
        check("pc_write",    pc_write_o,     e[39]);
        check("pc_redirect", pc_redirect_o,  e[38]);
        check("pc_target",   pc_target_o,    e[37:6]);
        check("if_id_flush", if_id_flush_o,  e[5]);
        check("if_id_stall", if_id_stall_o,  e[4]);
        check("id_ex_bubble", id_ex_bubble_o, e[3]);
        check("back_stall",  back_stall_o,   e[2]);
        check("state",       state_o,        e[1:0]);
        check("stall_cnt",   stall_cnt_o,    m_stall);
        check("flush_cnt",   flush_cnt_o,    m_flush);
        check("flush_stall_excl", if_id_flush_o && if_id_stall_o, 1'b0);
        @(posedge clk_i);
        #1;
        m_prev = n_prev; m_pend = n_pend; m_tgt = n_tgt; m_stall = n_stall; m_flush = n_flush;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        idle();
        @(posedge clk_i);
        #2;
        check("rst_pc_write", pc_write_o, 1'b1);
        check("rst_redirect", pc_redirect_o, 1'b0);
        check("rst_state", state_o, 2'(ST_RUN));
        check("rst_stall_cnt", stall_cnt_o, 32'd0);
        check("rst_flush_cnt", flush_cnt_o, 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        model_reset();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        idle();
        do_reset();

        // Load-use: one bubble cycle then resume.
        drive(0, 0, 0, 32'h0, 1, 5'd5, 5'd5, 5'd0, 1, 0); step();
        check("lu_state", state_o, 2'(ST_LU));
        drive(0, 0, 0, 32'h0, 0, 5'd5, 5'd5, 5'd0, 1, 0); step();
        check("lu_exit_state", state_o, 2'(ST_RUN));

        // Load to x0 is not a hazard.
        drive(0, 0, 0, 32'h0, 1, 5'd0, 5'd0, 5'd0, 1, 1); step();

        // Hazard held for three cycles: bubble, pass, bubble.
        repeat (3) begin drive(0, 0, 0, 32'h0, 1, 5'd7, 5'd1, 5'd7, 0, 1); step(); end
        idle(); step();

        // Redirect during a D-miss replays on release.
        do_reset();
        drive(0, 1, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0); step();
        drive(0, 1, 1, 32'h40, 0, 5'd0, 5'd0, 5'd0, 0, 0); step();
        drive(0, 1, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0); step();
        drive(0, 1, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0); step();
        idle(); step();
        check("dmiss_flush_cnt", flush_cnt_o, 32'd1);
        check("dmiss_stall_cnt", stall_cnt_o, 32'd4);

        // Redirect and load-use together: flush wins, no LU state.
        drive(0, 0, 1, 32'h100, 1, 5'd3, 5'd3, 5'd0, 1, 0); step();
        check("redir_lu_state", state_o, 2'(ST_RUN));
        idle(); step();

        // Double redirect during an I-miss: one replay to the newest target.
        do_reset();
        drive(1, 0, 1, 32'h80, 0, 5'd0, 5'd0, 5'd0, 0, 0); step();
        drive(1, 0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0); step();
        drive(1, 0, 1, 32'hC0, 0, 5'd0, 5'd0, 5'd0, 0, 0); step();
        idle(); step();
        idle(); step();
        check("imiss_flush_cnt", flush_cnt_o, 32'd1);

        // Asynchronous reset while frozen with a parked redirect.
        drive(0, 1, 1, 32'h200, 0, 5'd0, 5'd0, 5'd0, 0, 0); step();
        drive(0, 1, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0); step();
        #3;
        rst_i = 1'b0;
        #1;
        check("arst_pc_write", pc_write_o, 1'b1);
        check("arst_if_id_stall", if_id_stall_o, 1'b0);
        check("arst_back_stall", back_stall_o, 1'b0);
        check("arst_state", state_o, 2'(ST_RUN));
        check("arst_stall_cnt", stall_cnt_o, 32'd0);
        idle();
        #1;
        rst_i = 1'b1;
        model_reset();
        #1;
        check("arst_no_replay", pc_redirect_o, 1'b0);
        @(posedge clk_i);
        #1;
        repeat (3) begin idle(); step(); end
        check("arst_flush_cnt", flush_cnt_o, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 9) < 2, $urandom_range(0, 9) < 2,
                  $urandom_range(0, 9) < 2, $urandom,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
